// File: rtl/sseg_pkg.sv
// sseg_pkg: shared types and anode helper for the seven-segment scan controller
package sseg_pkg;
  localparam int NUM_DIGITS_DEFAULT = 4;
  typedef logic [3:0] digit_t;
  function automatic logic [7:0] an_onehot(input logic [2:0] idx, input logic en, input logic active_low);
    logic [7:0] v;
    v = en ? (8'd1 << idx) : 8'd0;
    return active_low ? ~v : v;
  endfunction
endpackage

// File: rtl/sseg_slot_timer.sv
// sseg_slot_timer: prescale counter and digit slot index with frame and dead-time flags
module sseg_slot_timer #(
  parameter int PRESCALE = 50000,
  parameter int NUM_DIGITS = 4,
  parameter int BLANK_CYCLES = 500,
  localparam int CW = $clog2(PRESCALE),
  localparam int IW = $clog2(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [IW-1:0] idx,
  output logic          slot_wrap,
  output logic          frame_end,
  output logic          in_dead_time
);
  logic [CW-1:0] cnt;
  assign slot_wrap = cnt == CW'(PRESCALE - 1);
  assign frame_end = slot_wrap && idx == IW'(NUM_DIGITS - 1);
  assign in_dead_time = cnt < CW'(BLANK_CYCLES);
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= slot_wrap ? '0 : cnt + 1'b1;
      if (slot_wrap) idx <= frame_end ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: rtl/sseg_digit_scanner.sv
// sseg_digit_scanner: double-buffered multiplexed scan of a common-anode seven-segment display
module sseg_digit_scanner
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT,
  parameter int PRESCALE = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int AN_ACTIVE_LOW = 1,
  localparam int IW = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    blank_lz,
  output digit_t                  hex,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           digit_idx
);
  logic [IW-1:0] idx;
  logic slot_wrap, frame_end, in_dead_time, pend_full, blank_q, above, unused;
  logic [4*NUM_DIGITS-1:0] disp_data, pend_data;
  logic [NUM_DIGITS-1:0] disp_dp, pend_dp, sup;
  logic [7:0] an_full;
  sseg_slot_timer #(.PRESCALE(PRESCALE), .NUM_DIGITS(NUM_DIGITS), .BLANK_CYCLES(BLANK_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .idx(idx),
    .slot_wrap(slot_wrap),
    .frame_end(frame_end),
    .in_dead_time(in_dead_time)
  );
  assign load_ready = !pend_full;
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_data <= '0;
      disp_dp <= '0;
      pend_data <= '0;
      pend_dp <= '0;
      pend_full <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_lz;
      if (frame_end && pend_full) begin
        disp_data <= pend_data;
        disp_dp <= pend_dp;
        pend_full <= 1'b0;
      end else if (load_valid && !pend_full) begin
        pend_data <= load_data;
        pend_dp <= load_dp;
        pend_full <= 1'b1;
      end
    end
  end
  // A digit blanks only if everything above it also blanks; digit 0 always shows
  always_comb begin
    sup = '0;
    above = blank_q;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      sup[i] = above && disp_data[4*i +: 4] == 4'h0 && !disp_dp[i];
      above = sup[i];
    end
  end
  assign an_full = an_onehot(3'(idx), !in_dead_time && !sup[idx], AN_ACTIVE_LOW != 0);
  assign an = an_full[NUM_DIGITS-1:0];
  assign unused = ^{an_full, slot_wrap};
  assign hex = disp_data[4*idx +: 4];
  assign dp = disp_dp[idx];
  assign digit_idx = idx;
endmodule
